serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Time-shares a single full_adder cell across

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_add_ctrl_full_adder.sv | 18 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_add_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell, the one datapath element the controller time-shares.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);

    // Plain sum/majority equations for one bit position.
    always_comb begin
        sum_out   = a_in ^ b_in ^ c_in;
        carry_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB first, one bit per clock.
// Latency: start accepted on edge k -> done_out high in the cycle after edge k+WIDTH.
// Backpressure: ready_out low during RUN/DONE; start_in is ignored there, nothing is queued.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8    // legal range 2..WIDTH_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_ff;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a_in      (a_sr[0]),
        .b_in      (b_sr[0]),
        .c_in      (c_ff),
        .sum_out   (fa_sum),
        .carry_out (fa_carry)
    );

    // New sum bit enters at the MSB so after WIDTH steps bit 0 has reached position 0.
    always_comb begin
        s_next = (s_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    end

    // Control FSM, operand/sum shift registers, carry FF and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            c_ff      <= 1'b0;
            cnt       <= '0;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        a_sr      <= a_in;
                        b_sr      <= b_in;
                        s_sr      <= '0;
                        c_ff      <= carry_in;
                        cnt       <= '0;
                        state     <= ST_RUN;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c_ff <= fa_carry;
                    if (cnt == LAST_BIT) begin
                        // Last bit: publish the complete result in one go.
                        cnt       <= '0;
                        state     <= ST_DONE;
                        busy_out  <= 1'b0;
                        done_out  <= 1'b1;
                        sum_out   <= s_next;
                        carry_out <= fa_carry;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    ready_out <= 1'b1;
                end
                default: begin
                    // Unreachable encoding recovers to IDLE.
                    state     <= ST_IDLE;
                    ready_out <= 1'b1;
                    busy_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=4 instances).
// Reference: {carry,sum} = a + b + cin, and done exactly WIDTH edges after start.
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, ready4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start8),
        .a_in      (a8),
        .b_in      (b8),
        .carry_in  (cin8),
        .ready_out (ready8),
        .busy_out  (busy8),
        .done_out  (done8),
        .sum_out   (sum8),
        .carry_out (cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start4),
        .a_in      (a4),
        .b_in      (b4),
        .carry_in  (cin4),
        .ready_out (ready4),
        .busy_out  (busy4),
        .done_out  (done4),
        .sum_out   (sum4),
        .carry_out (cout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition; optional ignored start pulse with a_in=AA mid-RUN.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit glitch, input string tag);
        logic [8:0] expv;
        int e;
        int bad;
        int extra;
        expv = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        @(negedge clk);
        check({tag, " ready before"}, ready8, 1);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        e = 0;
        bad = 0;
        while (e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done8) break;
            if (ready8 !== 1'b0 || busy8 !== 1'b1) bad++;
            a8 = 8'($urandom); b8 = 8'($urandom);
            start8 = glitch && (e == 3);
            if (glitch && e == 3) a8 = 8'hAA;
        end
        start8 = 1'b0;
        check({tag, " latency"}, 64'(e), 64'd8);
        check({tag, " result"}, {cout8, sum8}, expv);
        check({tag, " ready/busy in run"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, " done width"}, done8, 0);
        check({tag, " ready back"}, ready8, 1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8 || !ready8) extra++;
        end
        check({tag, " no extra done"}, 64'(extra), 64'd0);
        check({tag, " result held"}, {cout8, sum8}, expv);
    endtask

    initial begin
        logic [8:0] e4;
        int w;
        int dcount;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;

        // Reset state held across 5 clocks
        repeat (5) @(negedge clk);
        check("rst ready", ready8, 1);
        check("rst busy", busy8, 0);
        check("rst done", done8, 0);
        check("rst sum", sum8, 0);
        check("rst carry", cout8, 0);
        check("rst4 ready/busy", {ready4, busy4, done4}, 3'b100);
        rst_n = 1'b1;

        // Directed cases
        run8(8'h0F, 8'h01, 1'b0, 1'b0, "0F+01");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, "FF+01");
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, "FF+FF+1");
        run8(8'h05, 8'h03, 1'b0, 1'b1, "ignored start");

        // Reset 3 cycles into RUN aborts the operation
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort outputs", {ready8, busy8, done8, cout8, sum8}, {3'b100, 9'd0});
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        check("abort no done", 64'(dcount), 64'd0);
        rst_n = 1'b1;
        run8(8'h12, 8'h34, 1'b0, 1'b0, "after abort");

        // Random operands
        for (int i = 0; i < 30; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");

        // Exhaustive WIDTH=4, each start issued as soon as ready returns
        for (int i = 0; i < 512; i++) begin
            w = 0;
            @(negedge clk);
            while (!ready4 && w < 20) begin
                @(negedge clk);
                w++;
            end
            start4 = 1'b1; a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
            e4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            e4 = e4 & 9'h1F;
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            w = 0;
            while (!done4 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("w4 sum", {cout4, sum4}, e4[4:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
